capture_readout_ctrl: RTL and testbench

CAPTURE_READOUT_CTRL -- requirements
Module: capture_readout_ctrl

---
 rtl/capture_readout_ctrl.sv | 175 +++++++++++++++++
 tb/tb_capture_readout_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout_ctrl.sv
// capture_readout_ctrl: runs the sampler, then streams one frame over the UART.
// The frame is HEADER followed by sample memory from address 0 upward.
//
// Ports
//   clk_50mhz        : single clock, all logic on its rising edge
//   reset            : asynchronous active-low reset
//   activate         : capture-and-send request, sampled as a level in IDLE
//   abort            : cancels an operation in progress
//   busy             : high in every state except IDLE
//   done / error     : one-cycle completion pulse; error=1 on timeout or abort
//   sampler_activate : held high while the sampler runs
//   sampler_done     : sampler completion
//   mem_addr/mem_oe  : sample-memory read address and read enable
//   mem_data         : asynchronous read data for mem_addr
//   tx_data/tx_start : byte and one-cycle start request to the UART
//   tx_active        : UART transmitter busy
//   tx_done          : one-cycle pulse when a UART byte finishes
module capture_readout_ctrl #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [7:0]  HEADER     = 8'hA5,
   parameter logic [31:0] TIMEOUT    = 32'd50_000_000
) (
   input  logic                  clk_50mhz,
   input  logic                  reset,
   input  logic                  activate,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  sampler_activate,
   input  logic                  sampler_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_oe,
   input  logic [7:0]            mem_data,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_active,
   input  logic                  tx_done
);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      LOAD,
      SEND,
      WAIT_TX,
      FINISH
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t      state;
   logic [31:0] timer;
   logic        hdr_sent;    // header byte already transmitted
   logic        abort_pend;  // abort seen while a UART byte was in flight

   // Control FSM with registered outputs
   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         timer            <= '0;
         hdr_sent         <= 1'b0;
         abort_pend       <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         sampler_activate <= 1'b0;
         mem_addr         <= '0;
         mem_oe           <= 1'b0;
         tx_data          <= '0;
         tx_start         <= 1'b0;
      end else begin
         // single-cycle strobes
         done     <= 1'b0;
         tx_start <= 1'b0;
         mem_oe   <= 1'b0;

         unique case (state)
            IDLE: begin
               if (activate && !abort) begin
                  state            <= SAMPLE;
                  busy             <= 1'b1;
                  sampler_activate <= 1'b1;
                  timer            <= '0;
                  mem_addr         <= '0;
                  hdr_sent         <= 1'b0;
                  abort_pend       <= 1'b0;
               end
            end

            // sampler_done outranks the timeout when both land together
            SAMPLE: begin
               if (abort) begin
                  state            <= FINISH;
                  sampler_activate <= 1'b0;
                  done             <= 1'b1;
                  error            <= 1'b1;
               end else if (sampler_done) begin
                  state            <= SEND;
                  sampler_activate <= 1'b0;
                  tx_data          <= HEADER;
                  hdr_sent         <= 1'b0;
               end else if (timer == TIMEOUT - 32'd1) begin
                  state            <= FINISH;
                  sampler_activate <= 1'b0;
                  done             <= 1'b1;
                  error            <= 1'b1;
               end else begin
                  timer <= timer + 32'd1;
               end
            end

            // mem_oe was raised on entry, so it is high for exactly this cycle
            LOAD: begin
               if (abort) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  error <= 1'b1;
               end else begin
                  tx_data <= mem_data;
                  state   <= SEND;
               end
            end

            SEND: begin
               if (abort) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  error <= 1'b1;
               end else if (!tx_active) begin
                  tx_start <= 1'b1;
                  state    <= WAIT_TX;
               end
            end

            // byte in flight: an abort is remembered and honoured at tx_done
            WAIT_TX: begin
               if (abort) begin
                  abort_pend <= 1'b1;
               end
               if (tx_done) begin
                  if (abort || abort_pend) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     error <= 1'b1;
                  end else if (!hdr_sent) begin
                     hdr_sent <= 1'b1;
                     mem_oe   <= 1'b1;
                     state    <= LOAD;
                  end else if (mem_addr == LAST_ADDR) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     error <= 1'b0;
                  end else begin
                     mem_addr <= mem_addr + ADDR_WIDTH'(1);
                     mem_oe   <= 1'b1;
                     state    <= LOAD;
                  end
               end
            end

            FINISH: begin
               busy  <= 1'b0;
               error <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Directed bench for capture_readout_ctrl: cycle vectors, then frame-level sequences
// driven by a sampler model, an identity sample memory and a UART model.
module tb_capture_readout_ctrl;

   localparam int unsigned AW = 8;

   logic          clk;
   logic          reset;
   logic          activate;
   logic          abort;
   logic          busy;
   logic          done;
   logic          error;
   logic          sampler_activate;
   logic          sampler_done;
   logic [AW-1:0] mem_addr;
   logic          mem_oe;
   logic [7:0]    mem_data;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_active;
   logic          tx_done;

   logic drv_sd, drv_ta, drv_td, force_ta;
   logic smp_sd, uart_active, uart_done;
   logic uart_en, sampler_en, clr_mon;

   assign sampler_done = drv_sd | smp_sd;
   assign tx_active    = drv_ta | force_ta | uart_active;
   assign tx_done      = drv_td | uart_done;
   assign mem_data     = 8'(mem_addr);

   logic [21:0] outs;
   assign outs = {busy, done, error, sampler_activate, tx_start, mem_oe, tx_data, mem_addr};

   capture_readout_ctrl #(
      .ADDR_WIDTH (AW),
      .HEADER     (8'hA5),
      .TIMEOUT    (32'd100)
   ) dut (
      .clk_50mhz        (clk),
      .reset            (reset),
      .activate         (activate),
      .abort            (abort),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .sampler_activate (sampler_activate),
      .sampler_done     (sampler_done),
      .mem_addr         (mem_addr),
      .mem_oe           (mem_oe),
      .mem_data         (mem_data),
      .tx_data          (tx_data),
      .tx_start         (tx_start),
      .tx_active        (tx_active),
      .tx_done          (tx_done)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // sampler model: sampler_done 10 cycles after sampler_activate rises
   int scnt;
   always @(negedge clk) begin
      smp_sd <= 1'b0;
      if (sampler_en && sampler_activate) begin
         if (scnt == 9) smp_sd <= 1'b1;
         scnt <= scnt + 1;
      end else begin
         scnt <= 0;
      end
   end

   // UART model: busy after tx_start, tx_done pulse 20 cycles later
   int ucnt;
   always @(negedge clk) begin
      uart_done <= 1'b0;
      if (!uart_en) begin
         uart_active <= 1'b0;
         ucnt        <= 0;
      end else if (uart_active) begin
         if (ucnt == 19) begin
            uart_active <= 1'b0;
            uart_done   <= 1'b1;
         end
         ucnt <= ucnt + 1;
      end else if (tx_start) begin
         uart_active <= 1'b1;
         ucnt        <= 0;
      end
   end

   // monitor: sent bytes and event counters
   logic [7:0] byte_q[$];
   logic [7:0] cur_byte;
   logic       prev_ts;
   int done_cnt, ts_cnt, consec_cnt, stab_cnt, sa_cnt, txd_cnt;
   always @(negedge clk) begin
      if (clr_mon) begin
         byte_q.delete();
         done_cnt   <= 0;
         ts_cnt     <= 0;
         consec_cnt <= 0;
         stab_cnt   <= 0;
         sa_cnt     <= 0;
         txd_cnt    <= 0;
         prev_ts    <= 1'b0;
         cur_byte   <= 8'h00;
      end else begin
         if (tx_start) begin
            byte_q.push_back(tx_data);
            cur_byte <= tx_data;
            ts_cnt   <= ts_cnt + 1;
         end
         if (tx_start && prev_ts) consec_cnt <= consec_cnt + 1;
         if (uart_active && tx_data !== cur_byte) stab_cnt <= stab_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (sampler_activate) sa_cnt <= sa_cnt + 1;
         if (uart_done) txd_cnt <= txd_cnt + 1;
         prev_ts <= tx_start;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      clr_mon = 1'b1;
      step();
      clr_mon = 1'b0;
   endtask

   task automatic pulse_activate();
      activate = 1'b1;
      step();
      activate = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (byte_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [7:0] qat(input int i);
      if (i < byte_q.size()) return byte_q[i];
      return 8'bx;
   endfunction

   typedef struct {
      logic        act, abt, sd, ta, td;
      logic [21:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic act, abt, sd, ta, td,
                               input logic b, d, e, sa, ts, oe,
                               input logic [7:0] txd, input logic [7:0] addr);
      vec_t v;
      v.act = act; v.abt = abt; v.sd = sd; v.ta = ta; v.td = td;
      v.exp = {b, d, e, sa, ts, oe, txd, addr};
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      bit   ok;
      int   bad;

      //            act abt sd ta td   busy done err sa ts oe  txd    addr
      tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h00, 8'h00)); // idle
      tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h00, 8'h00)); // act+abort stays idle
      tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 8'h00, 8'h00)); // -> SAMPLE
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00)); // -> SEND header
      tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00)); // tx busy: hold
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 8'hA5, 8'h00)); // tx_start
      tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 8'hA5, 8'h00)); // header done -> LOAD
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00)); // mem[0] loaded
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 8'h00, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 8'h00, 8'h01)); // sample done: addr++
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8'h01, 8'h01));
      tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 8'h01, 8'h01)); // abort in SEND
      tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h01, 8'h01));
      tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 8'h01, 8'h00)); // restart clears addr
      tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 8'h01, 8'h00)); // abort in SAMPLE
      tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'h01, 8'h00));
      tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 8'h01, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 8'hA5, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 8'hA5, 8'h00)); // -> LOAD
      tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 8'hA5, 8'h00)); // abort in LOAD
      tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'hA5, 8'h00));
      tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 8'hA5, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 8'hA5, 8'h00)); // WAIT_TX
      tbl.push_back(mk(0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00)); // abort: keep waiting
      tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'hA5, 8'h00)); // abort dropped
      tbl.push_back(mk(0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 8'hA5, 8'h00)); // tx_done -> FINISH err
      tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'hA5, 8'h00));

      reset = 1'b0; activate = 1'b0; abort = 1'b0;
      drv_sd = 1'b0; drv_ta = 1'b0; drv_td = 1'b0; force_ta = 1'b0;
      uart_en = 1'b0; sampler_en = 1'b0; clr_mon = 1'b1;
      repeat (3) step();
      chk("reset_outputs", 32'(outs), 32'h0);
      reset   = 1'b1;
      clr_mon = 1'b0;

      // cycle-level vectors
      for (int i = 0; i < tbl.size(); i++) begin
         activate = tbl[i].act;
         abort    = tbl[i].abt;
         drv_sd   = tbl[i].sd;
         drv_ta   = tbl[i].ta;
         drv_td   = tbl[i].td;
         step();
         chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
      end
      activate = 1'b0; abort = 1'b0; drv_sd = 1'b0; drv_ta = 1'b0; drv_td = 1'b0;

      // sampler_done on the last timeout cycle still wins
      pulse_activate();
      repeat (99) step();
      chk("race_sa_high", 32'(sampler_activate), 32'd1);
      drv_sd = 1'b1;
      step();
      drv_sd = 1'b0;
      chk("race_to_send", 32'({busy, done, error, sampler_activate, tx_data}), 32'({4'b1000, 8'hA5}));
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("race_abort_done", 32'({done, error}), 32'b11);
      step();

      // full frame
      uart_en = 1'b1; sampler_en = 1'b1;
      clr();
      pulse_activate();
      wait_done(20000, ok);
      chk("frame_done_seen", 32'(ok), 32'd1);
      chk("frame_error", 32'(error), 32'd0);
      step();
      chk("frame_busy_after", 32'(busy), 32'd0);
      chk("frame_len", 32'(byte_q.size()), 32'd257);
      bad = 0;
      for (int i = 0; i < 257; i++) begin
         if (qat(i) !== ((i == 0) ? 8'hA5 : 8'(i - 1))) bad++;
      end
      chk("frame_content_bad_bytes", 32'(bad), 32'd0);
      chk("frame_done_count", 32'(done_cnt), 32'd1);
      chk("frame_consec_tx_start", 32'(consec_cnt), 32'd0);
      chk("frame_tx_data_stable", 32'(stab_cnt), 32'd0);

      // sampler timeout
      sampler_en = 1'b0;
      clr();
      pulse_activate();
      wait_done(500, ok);
      chk("timeout_done_seen", 32'(ok), 32'd1);
      chk("timeout_error", 32'(error), 32'd1);
      step();
      chk("timeout_sa_cycles", 32'(sa_cnt), 32'd100);
      chk("timeout_no_tx", 32'(ts_cnt), 32'd0);
      sampler_en = 1'b1;

      // abort while byte 0x40 is on the wire
      clr();
      pulse_activate();
      wait_bytes(66, 5000, ok);
      chk("abort40_reached", 32'(ok), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_done(100, ok);
      chk("abort40_done_seen", 32'(ok), 32'd1);
      chk("abort40_error", 32'(error), 32'd1);
      step();
      chk("abort40_no_more_tx", 32'(byte_q.size()), 32'd66);
      chk("abort40_last_byte", 32'(qat(65)), 32'h40);
      chk("abort40_byte_completed", 32'(txd_cnt), 32'd66);

      // transmitter busy at SEND entry
      clr();
      force_ta = 1'b1;
      pulse_activate();
      for (int i = 0; i < 60 && sampler_activate; i++) step();
      chk("txbusy_in_send", 32'({busy, sampler_activate}), 32'b10);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx_start || tx_data !== 8'hA5) bad++;
         if (i < 49) step();
      end
      chk("txbusy_held_off", 32'(bad), 32'd0);
      force_ta = 1'b0;
      step();
      chk("txbusy_start", 32'({tx_start, tx_data}), 32'({1'b1, 8'hA5}));
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_done(100, ok);
      chk("txbusy_abort_done", 32'({ok, error}), 32'b11);
      step();

      // reset while byte 0x10 is on the wire
      clr();
      pulse_activate();
      wait_bytes(18, 2000, ok);
      chk("reset10_reached", 32'(ok), 32'd1);
      step();
      #2 reset = 1'b0;
      #1 chk("reset10_async_outs", 32'(outs), 32'h0);
      repeat (30) step();
      chk("reset10_no_done", 32'(done_cnt), 32'd0);
      reset = 1'b1;
      clr();
      pulse_activate();
      wait_done(20000, ok);
      chk("reset10_refrm_done", 32'({ok, error}), 32'b10);
      step();
      chk("reset10_refrm_len", 32'(byte_q.size()), 32'd257);
      chk("reset10_refrm_head", 32'({qat(0), qat(1)}), 32'h0000A500);

      // activate held high: back-to-back frames
      clr();
      activate = 1'b1;
      wait_done(20000, ok);
      chk("b2b_first_done", 32'({ok, error}), 32'b10);
      wait_done(20000, ok);
      chk("b2b_second_done", 32'({ok, error}), 32'b10);
      activate = 1'b0;
      step();
      step();
      chk("b2b_idle_after", 32'(busy), 32'd0);
      chk("b2b_done_count", 32'(done_cnt), 32'd2);
      chk("b2b_len", 32'(byte_q.size()), 32'd514);
      chk("b2b_headers", 32'({qat(0), qat(257)}), 32'h0000A5A5);
      chk("b2b_stable", 32'({consec_cnt[15:0], stab_cnt[15:0]}), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
